// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use and branch handling,
// and a data-memory wait FSM with sticky timeout error and stall counter.
module hazard_ctrl #(
    parameter int REG_WIDTH = 4,
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] i_rs1_D,
    input  logic [REG_WIDTH-1:0] i_rs2_D,
    input  logic [REG_WIDTH-1:0] i_rs1_E,
    input  logic [REG_WIDTH-1:0] i_rs2_E,
    input  logic [REG_WIDTH-1:0] i_rd_E,
    input  logic [1:0]           i_result_src_E,
    input  logic                 i_pc_src_E,
    input  logic [REG_WIDTH-1:0] i_rd_M,
    input  logic [REG_WIDTH-1:0] i_rd_WB,
    input  logic                 i_reg_write_M,
    input  logic                 i_reg_write_WB,
    input  logic                 i_mem_req_M,
    input  logic                 i_mem_ready,
    output logic                 o_stall_F,
    output logic                 o_stall_D,
    output logic                 o_stall_E,
    output logic                 o_stall_M,
    output logic                 o_flush_D,
    output logic                 o_flush_E,
    output logic                 o_flush_WB,
    output logic [1:0]           o_forward_a_E,
    output logic [1:0]           o_forward_b_E,
    output logic                 o_mem_err,
    output logic [CNT_WIDTH-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lw_stall;
    logic       mem_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_WIDTH-1:0] rs,
        input logic [REG_WIDTH-1:0] rd_m,
        input logic                 we_m,
        input logic [REG_WIDTH-1:0] rd_wb,
        input logic                 we_wb
    );
        if (we_m && rd_m != '0 && rd_m == rs)
            return 2'b10;
        else if (we_wb && rd_wb != '0 && rd_wb == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lw_stall = (i_result_src_E == 2'b01) && (i_rd_E != '0) &&
                      (i_rd_E == i_rs1_D || i_rd_E == i_rs2_D);

    assign mem_stall = (state == RUN && i_mem_req_M && !i_mem_ready) ||
                       (state == MEM_WAIT && !i_mem_ready) ||
                       (state == ERR);

    // Memory stall outranks branch, which outranks load-use.
    always_comb begin
        o_stall_F     = 1'b0;
        o_stall_D     = 1'b0;
        o_stall_E     = 1'b0;
        o_stall_M     = 1'b0;
        o_flush_D     = 1'b0;
        o_flush_E     = 1'b0;
        o_flush_WB    = 1'b0;
        o_forward_a_E = 2'b00;
        o_forward_b_E = 2'b00;
        if (!rst) begin
            o_forward_a_E = fwd_sel(i_rs1_E, i_rd_M, i_reg_write_M,
                                    i_rd_WB, i_reg_write_WB);
            o_forward_b_E = fwd_sel(i_rs2_E, i_rd_M, i_reg_write_M,
                                    i_rd_WB, i_reg_write_WB);
            if (mem_stall) begin
                o_stall_F  = 1'b1;
                o_stall_D  = 1'b1;
                o_stall_E  = 1'b1;
                o_stall_M  = 1'b1;
                o_flush_WB = 1'b1;
            end else if (i_pc_src_E) begin
                o_flush_D = 1'b1;
                o_flush_E = 1'b1;
            end else if (lw_stall) begin
                o_stall_F = 1'b1;
                o_stall_D = 1'b1;
                o_flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            o_mem_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (i_mem_req_M && !i_mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (i_mem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= ERR;
                        o_mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ERR:     state <= ERR;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_stall_cycles <= '0;
        else if (o_stall_F && o_stall_cycles != '1)
            o_stall_cycles <= o_stall_cycles + 1'b1;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 4, the register-address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, the maximum data-memory wait cycles before error (legal range 2..255).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, the stall-counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports i_rs1_D and i_rs2_D, input, REG_WIDTH each: source registers of the instruction in decode.
REQ-007 SHALL have ports i_rs1_E, i_rs2_E and i_rd_E, input, REG_WIDTH each: source and destination registers in execute.
REQ-008 SHALL have port i_result_src_E, input, 2 bits: value 2'b01 marks a load in execute.
REQ-009 SHALL have port i_pc_src_E, input, 1 bit: taken branch/jump resolved in execute.
REQ-010 SHALL have ports i_rd_M and i_rd_WB, input, REG_WIDTH each: destination registers in memory and writeback.
REQ-011 SHALL have ports i_reg_write_M and i_reg_write_WB, input, 1 bit each: register-write enables.
REQ-012 SHALL have ports i_mem_req_M and i_mem_ready, input, 1 bit each: data-memory access request in memory stage, and its completion.
REQ-013 SHALL have ports o_stall_F, o_stall_D, o_stall_E and o_stall_M, output, 1 bit each: hold the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-014 SHALL have ports o_flush_D, o_flush_E and o_flush_WB, output, 1 bit each: clear IF/ID, clear ID/EX, and insert a bubble into MEM/WB (reg_write=0).
REQ-015 SHALL have ports o_forward_a_E and o_forward_b_E, output, 2 bits each: forwarding select, 00 = register file, 01 = WB result, 10 = MEM ALU result.
REQ-016 SHALL have port o_mem_err, output, 1 bit: sticky memory-timeout error.
REQ-017 SHALL have port o_stall_cycles, output, CNT_WIDTH: saturating count of stalled cycles.

Function
REQ-018 SHALL implement an FSM with states RUN, MEM_WAIT and ERR, plus a wait counter of at least 8 bits.
REQ-019 SHALL set forward_a to 10 when i_reg_write_M=1, i_rd_M!=0 and i_rd_M==i_rs1_E; otherwise to 01 under the same rule using the WB ports; otherwise to 00. The MEM match has priority. forward_b uses i_rs2_E by the same rule.
REQ-020 SHALL compute lw_stall = (i_result_src_E==01) & (i_rd_E!=0) & (i_rd_E==i_rs1_D | i_rd_E==i_rs2_D).
REQ-021 SHALL compute mem_stall = (RUN & i_mem_req_M & !i_mem_ready) | (MEM_WAIT & !i_mem_ready) | ERR.
REQ-022 SHALL, when mem_stall=1, assert o_stall_F/D/E/M=1 and o_flush_WB=1, and deassert o_flush_D/E; branch and load-use are ignored that cycle.
REQ-023 SHALL, when mem_stall=0 and i_pc_src_E=1, assert o_flush_D=1 and o_flush_E=1 and leave all stalls at 0; the branch overrides lw_stall.
REQ-024 SHALL, when mem_stall=0, i_pc_src_E=0 and lw_stall=1, assert o_stall_F=1, o_stall_D=1 and o_flush_E=1.
REQ-025 SHALL drive all stall and flush outputs combinationally, with zero-cycle latency from the inputs and state.
REQ-026 SHALL transition RUN->MEM_WAIT when i_mem_req_M & !i_mem_ready, loading the wait counter with 1.
REQ-027 SHALL, in MEM_WAIT, transition to RUN when i_mem_ready=1 (stall released in that same cycle); otherwise it increments the wait counter.
REQ-028 SHALL transition MEM_WAIT->ERR when the counter equals TIMEOUT-1 and i_mem_ready=0; this gives TIMEOUT total stalled cycles before ERR.
REQ-029 SHALL keep ERR terminal until reset, with o_mem_err=1 registered from the cycle after entry.
REQ-030 SHALL increment o_stall_cycles on each clock edge where o_stall_F=1, saturating at all-ones with no wrap.

Reset
REQ-031 SHALL, on rst=1 and asynchronously, set state=RUN, the wait counter to 0, o_mem_err=0 and o_stall_cycles=0.
REQ-032 SHALL, while rst=1, force all stall and flush outputs to 0 and both forward selects to 00; reset mid-wait discards the wait.
REQ-033 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-034 SHALL cover forwarding: rs1_E=3, rd_M=3, rd_WB=3, both write enables=1 -> forward_a=10; then rd_M=0 -> forward_a=01.
REQ-035 SHALL cover load-use: result_src_E=01, rd_E=5, rs2_D=5 -> stall_F=stall_D=flush_E=1 for one cycle; with rd_E=0 -> no stall.
REQ-036 SHALL cover branch vs load-use: pc_src_E=1 together with a lw_stall condition -> flush_D=flush_E=1, stall_F=0.
REQ-037 SHALL cover memory wait: mem_req_M=1 with ready low for 3 cycles, then high -> stall_F/D/E/M=1 and flush_WB=1 for 3 cycles, released in the ready cycle, and o_stall_cycles=3.
REQ-038 SHALL cover timeout: ready held low, TIMEOUT=4 -> stalls for 4 cycles, ERR entered, o_mem_err=1 and stalls held; asserting rst -> all outputs 0.
REQ-039 SHALL cover saturation: CNT_WIDTH=4 with 20 stalled cycles -> o_stall_cycles=15.
